// File: rtl/commit_trace_buffer.sv
// Retirement trace buffer: captures retired instructions into a circular
// store, freezes on trigger/post-count (MODE 0) or on full (MODE 1), then
// drains the frozen window oldest-first over a valid/ready port.
module commit_trace_buffer #(
  parameter int DEPTH     = 32,
  parameter int POST_TRIG = 8,
  parameter int STAMP_W   = 16,
  parameter int MODE      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               ret_valid_i,
  input  logic [31:0]        ret_pc_i,
  input  logic [31:0]        ret_instr_i,
  input  logic [31:0]        ret_rd_data_i,
  input  logic [4:0]         ret_rd_i,
  input  logic               ret_rf_wr_en_i,
  input  logic               trig_ext_i,
  input  logic               trig_pc_en_i,
  input  logic [31:0]        trig_pc_i,
  input  logic               rearm_i,
  input  logic               rd_ready_i,
  output logic               rd_valid_o,
  output logic [31:0]        rd_pc_o,
  output logic [31:0]        rd_instr_o,
  output logic [31:0]        rd_rd_data_o,
  output logic [4:0]         rd_rd_o,
  output logic               rd_rf_wr_en_o,
  output logic [STAMP_W-1:0] rd_stamp_o,
  output logic               rd_last_o,
  output logic [1:0]         state_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic               wrapped_o,
  output logic               triggered_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ARMED  = 2'b00,
    POST   = 2'b01,
    FROZEN = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t             state_reg, state_next;
  logic [AW-1:0]      wr_ptr_reg, wr_ptr_next, rd_ptr_reg;
  logic [CW-1:0]      count_reg, count_next, remain_reg;
  logic [AW-1:0]      post_cnt_reg, post_cnt_next;
  logic [STAMP_W-1:0] stamp_reg;
  logic               wrapped_reg, triggered_reg;
  logic               cap, trig, xfer, freeze, rd_valid;

  logic [31:0]        pc_mem    [DEPTH];
  logic [31:0]        instr_mem [DEPTH];
  logic [31:0]        data_mem  [DEPTH];
  logic [4:0]         rd_mem    [DEPTH];
  logic               wen_mem   [DEPTH];
  logic [STAMP_W-1:0] stamp_mem [DEPTH];

  // Capture / trigger / transfer decode; rearm suppresses a same-cycle capture
  always_comb begin
    cap  = en_i && ret_valid_i && !rearm_i && (state_reg == ARMED || state_reg == POST);
    trig = (MODE == 0) && (state_reg == ARMED) &&
           (trig_ext_i || (trig_pc_en_i && cap && ret_pc_i == trig_pc_i));
    xfer = (state_reg == FROZEN) && (remain_reg != '0) && rd_ready_i;
    wr_ptr_next = cap ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    count_next  = (cap && count_reg != FULL) ? count_reg + 1'b1 : count_reg;
  end

  // Next-state logic; the triggering retirement counts toward the post window
  always_comb begin
    state_next    = state_reg;
    post_cnt_next = post_cnt_reg;
    case (state_reg)
      ARMED: begin
        if (MODE == 0) begin
          if (trig) begin
            if (POST_TRIG == 0 || (cap && POST_TRIG == 1)) begin
              state_next = FROZEN;
            end else begin
              post_cnt_next = cap ? AW'(POST_TRIG - 1) : AW'(POST_TRIG);
              state_next    = POST;
            end
          end
        end else if (cap && count_next == FULL) begin
          state_next = FROZEN;
        end
      end
      POST: begin
        if (cap) begin
          post_cnt_next = post_cnt_reg - 1'b1;
          if (post_cnt_reg == AW'(1)) state_next = FROZEN;
        end
      end
      FROZEN: begin
        if (remain_reg == '0 || (xfer && remain_reg == CW'(1))) state_next = DONE;
      end
      default: state_next = state_reg;
    endcase
    freeze = (state_next == FROZEN) && (state_reg != FROZEN);
  end

  // Control registers; rearm clears everything exactly like reset
  always_ff @(posedge clk) begin
    if (rst || rearm_i) begin
      state_reg     <= ARMED;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      remain_reg    <= '0;
      post_cnt_reg  <= '0;
      stamp_reg     <= '0;
      wrapped_reg   <= 1'b0;
      triggered_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      post_cnt_reg <= post_cnt_next;
      stamp_reg    <= stamp_reg + 1'b1;
      if (cap && count_reg == FULL) wrapped_reg <= 1'b1;
      if (trig) triggered_reg <= 1'b1;
      if (freeze) begin
        // oldest surviving entry sits count positions behind the write pointer
        rd_ptr_reg <= wr_ptr_next - count_next[AW-1:0];
        remain_reg <= count_next;
      end else if (xfer) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        remain_reg <= remain_reg - 1'b1;
      end
    end
  end

  // Entry storage written at the write pointer on each capture
  always_ff @(posedge clk) begin
    if (cap) begin
      pc_mem[wr_ptr_reg]    <= ret_pc_i;
      instr_mem[wr_ptr_reg] <= ret_instr_i;
      data_mem[wr_ptr_reg]  <= ret_rd_data_i;
      rd_mem[wr_ptr_reg]    <= ret_rd_i;
      wen_mem[wr_ptr_reg]   <= ret_rf_wr_en_i;
      stamp_mem[wr_ptr_reg] <= stamp_reg;
    end
  end

  // Readout port: fields read at rd_ptr and forced to zero when not valid
  always_comb begin
    rd_valid      = (state_reg == FROZEN) && (remain_reg != '0);
    rd_valid_o    = rd_valid;
    rd_last_o     = rd_valid && (remain_reg == CW'(1));
    rd_pc_o       = rd_valid ? pc_mem[rd_ptr_reg]    : '0;
    rd_instr_o    = rd_valid ? instr_mem[rd_ptr_reg] : '0;
    rd_rd_data_o  = rd_valid ? data_mem[rd_ptr_reg]  : '0;
    rd_rd_o       = rd_valid ? rd_mem[rd_ptr_reg]    : '0;
    rd_rf_wr_en_o = rd_valid ? wen_mem[rd_ptr_reg]   : 1'b0;
    rd_stamp_o    = rd_valid ? stamp_mem[rd_ptr_reg] : '0;
    state_o       = state_reg;
    count_o       = count_reg;
    wrapped_o     = wrapped_reg;
    triggered_o   = triggered_reg;
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench: three configurations share one stimulus stream; each is checked
// every cycle against a queue-based model, plus table and hand sequences.
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;
  localparam int PT [3] = '{2, 0, 0};
  localparam int MD [3] = '{0, 0, 1};
  localparam int SW [3] = '{16, 4, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, ret_valid, ret_wen, trig_ext, trig_pc_en, rearm, rd_ready;
  logic [31:0] ret_pc, ret_instr, ret_data, trig_pc;
  logic [4:0]  ret_rd;

  logic        rd_valid  [3];
  logic        rd_last   [3];
  logic        wrapped   [3];
  logic        triggered [3];
  logic        rd_wen    [3];
  logic [31:0] rd_pc     [3];
  logic [31:0] rd_instr  [3];
  logic [31:0] rd_data   [3];
  logic [4:0]  rd_rd     [3];
  logic [1:0]  state     [3];
  logic [3:0]  count     [3];
  logic [15:0] stamp0, stamp2;
  logic [3:0]  stamp1;

  commit_trace_buffer #(.DEPTH(8), .POST_TRIG(2), .STAMP_W(16), .MODE(0)) u_pt2 (
    .clk(clk), .rst(rst), .en_i(en), .ret_valid_i(ret_valid), .ret_pc_i(ret_pc),
    .ret_instr_i(ret_instr), .ret_rd_data_i(ret_data), .ret_rd_i(ret_rd),
    .ret_rf_wr_en_i(ret_wen), .trig_ext_i(trig_ext), .trig_pc_en_i(trig_pc_en),
    .trig_pc_i(trig_pc), .rearm_i(rearm), .rd_ready_i(rd_ready),
    .rd_valid_o(rd_valid[0]), .rd_pc_o(rd_pc[0]), .rd_instr_o(rd_instr[0]),
    .rd_rd_data_o(rd_data[0]), .rd_rd_o(rd_rd[0]), .rd_rf_wr_en_o(rd_wen[0]),
    .rd_stamp_o(stamp0), .rd_last_o(rd_last[0]), .state_o(state[0]),
    .count_o(count[0]), .wrapped_o(wrapped[0]), .triggered_o(triggered[0]));

  commit_trace_buffer #(.DEPTH(8), .POST_TRIG(0), .STAMP_W(4), .MODE(0)) u_pt0 (
    .clk(clk), .rst(rst), .en_i(en), .ret_valid_i(ret_valid), .ret_pc_i(ret_pc),
    .ret_instr_i(ret_instr), .ret_rd_data_i(ret_data), .ret_rd_i(ret_rd),
    .ret_rf_wr_en_i(ret_wen), .trig_ext_i(trig_ext), .trig_pc_en_i(trig_pc_en),
    .trig_pc_i(trig_pc), .rearm_i(rearm), .rd_ready_i(rd_ready),
    .rd_valid_o(rd_valid[1]), .rd_pc_o(rd_pc[1]), .rd_instr_o(rd_instr[1]),
    .rd_rd_data_o(rd_data[1]), .rd_rd_o(rd_rd[1]), .rd_rf_wr_en_o(rd_wen[1]),
    .rd_stamp_o(stamp1), .rd_last_o(rd_last[1]), .state_o(state[1]),
    .count_o(count[1]), .wrapped_o(wrapped[1]), .triggered_o(triggered[1]));

  commit_trace_buffer #(.DEPTH(8), .POST_TRIG(0), .STAMP_W(16), .MODE(1)) u_full (
    .clk(clk), .rst(rst), .en_i(en), .ret_valid_i(ret_valid), .ret_pc_i(ret_pc),
    .ret_instr_i(ret_instr), .ret_rd_data_i(ret_data), .ret_rd_i(ret_rd),
    .ret_rf_wr_en_i(ret_wen), .trig_ext_i(trig_ext), .trig_pc_en_i(trig_pc_en),
    .trig_pc_i(trig_pc), .rearm_i(rearm), .rd_ready_i(rd_ready),
    .rd_valid_o(rd_valid[2]), .rd_pc_o(rd_pc[2]), .rd_instr_o(rd_instr[2]),
    .rd_rd_data_o(rd_data[2]), .rd_rd_o(rd_rd[2]), .rd_rf_wr_en_o(rd_wen[2]),
    .rd_stamp_o(stamp2), .rd_last_o(rd_last[2]), .state_o(state[2]),
    .count_o(count[2]), .wrapped_o(wrapped[2]), .triggered_o(triggered[2]));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic [15:0] stamp;
  } rec_t;

  rec_t mq [3][$];
  int   m_st [3], m_cnt [3], m_post [3], m_stamp [3];
  bit   m_trig [3], m_wrap [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input int inst, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cyc%0d: got %h expected %h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    mq[i].delete();
    m_st[i] = 0; m_cnt[i] = 0; m_post[i] = 0; m_stamp[i] = 0;
    m_trig[i] = 0; m_wrap[i] = 0;
  endtask

  // One clock of behaviour, driven by the inputs currently applied
  task automatic model_step(input int i);
    bit   cap, t;
    int   ns;
    rec_t r;
    if (rst || rearm) begin
      model_reset(i);
      return;
    end
    ns  = m_st[i];
    cap = en && ret_valid && (m_st[i] <= 1);
    if (cap) begin
      r.pc = ret_pc; r.instr = ret_instr; r.data = ret_data;
      r.rd = ret_rd; r.wen = ret_wen; r.stamp = 16'(m_stamp[i]);
      mq[i].push_back(r);
      if (mq[i].size() > DEPTH) begin
        r = mq[i].pop_front();
        m_wrap[i] = 1;
      end
      if (m_cnt[i] < DEPTH) m_cnt[i]++;
    end
    case (m_st[i])
      0: begin
        if (MD[i] == 0) begin
          t = trig_ext || (trig_pc_en && cap && ret_pc == trig_pc);
          if (t) begin
            m_trig[i] = 1;
            if (PT[i] == 0) ns = 2;
            else begin
              m_post[i] = PT[i] - (cap ? 1 : 0);
              ns = (m_post[i] == 0) ? 2 : 1;
            end
          end
        end else if (cap && m_cnt[i] == DEPTH) ns = 2;
      end
      1: if (cap) begin
        m_post[i]--;
        if (m_post[i] == 0) ns = 2;
      end
      2: begin
        if (mq[i].size() == 0) ns = 3;
        else if (rd_ready) begin
          r = mq[i].pop_front();
          if (mq[i].size() == 0) ns = 3;
        end
      end
      default: ns = m_st[i];
    endcase
    m_stamp[i] = (m_stamp[i] + 1) % (1 << SW[i]);
    m_st[i] = ns;
  endtask

  function automatic rec_t dut_rec(input int i);
    rec_t d;
    d.pc = rd_pc[i]; d.instr = rd_instr[i]; d.data = rd_data[i];
    d.rd = rd_rd[i]; d.wen = rd_wen[i];
    d.stamp = (i == 0) ? stamp0 : (i == 1) ? {12'h000, stamp1} : stamp2;
    return d;
  endfunction

  task automatic compare_all();
    bit   v, l;
    rec_t er;
    for (int i = 0; i < 3; i++) begin
      v  = (m_st[i] == 2) && (mq[i].size() > 0);
      l  = v && (mq[i].size() == 1);
      er = v ? mq[i][0] : '0;
      chk("valid", i, 128'(rd_valid[i]), 128'(v));
      chk("last", i, 128'(rd_last[i]), 128'(l));
      chk("state", i, 128'(state[i]), 128'(m_st[i]));
      chk("count", i, 128'(count[i]), 128'(m_cnt[i]));
      chk("wrapped", i, 128'(wrapped[i]), 128'(m_wrap[i]));
      chk("triggered", i, 128'(triggered[i]), 128'(m_trig[i]));
      chk("fields", i, 128'(dut_rec(i)), 128'(er));
    end
  endtask

  // Called just after a falling edge with inputs applied
  task automatic step();
    #1;
    compare_all();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_pulses();
    ret_valid = 0; trig_ext = 0; rearm = 0; rst = 0;
    ret_pc = 0; ret_instr = 0; ret_data = 0; ret_rd = 0; ret_wen = 0;
  endtask

  task automatic set_ret(input logic [31:0] pc);
    ret_valid = 1; ret_pc = pc; ret_instr = pc ^ 32'h1357_0000;
    ret_data = ~pc; ret_rd = pc[6:2]; ret_wen = pc[3];
  endtask

  task automatic ret(input logic [31:0] pc);
    clear_pulses(); set_ret(pc); step();
  endtask

  task automatic idle();
    clear_pulses(); step();
  endtask

  task automatic do_rearm();
    clear_pulses(); rearm = 1; step();
  endtask

  // ---------------- table-driven vectors for the POST_TRIG=2 instance ----------------
  typedef struct {
    int rv, pc, tx, rdy;
    int st, cnt, v, epc, last, trg;
  } vec_t;
  vec_t vt [18];

  int xf;
  int exp_st [4];
  bit pat [4];

  initial begin
    vt[0]  = '{0, 'h000, 0, 0, 0, 0, 0, 'h000, 0, 0};
    vt[1]  = '{1, 'h100, 0, 0, 0, 0, 0, 'h000, 0, 0};
    vt[2]  = '{1, 'h104, 0, 0, 0, 1, 0, 'h000, 0, 0};
    vt[3]  = '{1, 'h108, 0, 0, 0, 2, 0, 'h000, 0, 0};
    vt[4]  = '{1, 'h10C, 0, 0, 0, 3, 0, 'h000, 0, 0};
    vt[5]  = '{1, 'h110, 0, 0, 0, 4, 0, 'h000, 0, 0};
    vt[6]  = '{0, 'h000, 1, 0, 0, 5, 0, 'h000, 0, 0};
    vt[7]  = '{1, 'h114, 0, 0, 1, 5, 0, 'h000, 0, 1};
    vt[8]  = '{1, 'h118, 0, 0, 1, 6, 0, 'h000, 0, 1};
    vt[9]  = '{0, 'h000, 0, 0, 2, 7, 1, 'h100, 0, 1};
    vt[10] = '{0, 'h000, 0, 1, 2, 7, 1, 'h100, 0, 1};
    vt[11] = '{0, 'h000, 0, 1, 2, 7, 1, 'h104, 0, 1};
    vt[12] = '{0, 'h000, 0, 1, 2, 7, 1, 'h108, 0, 1};
    vt[13] = '{0, 'h000, 0, 1, 2, 7, 1, 'h10C, 0, 1};
    vt[14] = '{0, 'h000, 0, 1, 2, 7, 1, 'h110, 0, 1};
    vt[15] = '{0, 'h000, 0, 1, 2, 7, 1, 'h114, 0, 1};
    vt[16] = '{0, 'h000, 0, 1, 2, 7, 1, 'h118, 1, 1};
    vt[17] = '{0, 'h000, 0, 0, 3, 7, 0, 'h000, 0, 1};
    exp_st = '{0, 3, 14, 15};
    pat    = '{1'b1, 1'b0, 1'b0, 1'b1};

    clear_pulses();
    en = 1; trig_pc_en = 0; trig_pc = 0; rd_ready = 0; rst = 1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) model_reset(i);
    rst = 0;

    // reset values
    for (int i = 0; i < 3; i++) begin
      chk("rst_state", i, 128'(state[i]), 128'(0));
      chk("rst_count", i, 128'(count[i]), 128'(0));
      chk("rst_valid", i, 128'(rd_valid[i]), 128'(0));
      chk("rst_fields", i, 128'(dut_rec(i)), 128'(0));
    end

    // scenario: ext trigger with post count of 2
    for (int r = 0; r < 18; r++) begin
      clear_pulses();
      if (vt[r].rv != 0) set_ret(32'(vt[r].pc));
      trig_ext = 1'(vt[r].tx);
      rd_ready = 1'(vt[r].rdy);
      #1;
      chk("tbl_state", 0, 128'(state[0]), 128'(vt[r].st));
      chk("tbl_count", 0, 128'(count[0]), 128'(vt[r].cnt));
      chk("tbl_valid", 0, 128'(rd_valid[0]), 128'(vt[r].v));
      chk("tbl_pc", 0, 128'(rd_pc[0]), 128'(vt[r].epc));
      chk("tbl_last", 0, 128'(rd_last[0]), 128'(vt[r].last));
      chk("tbl_trig", 0, 128'(triggered[0]), 128'(vt[r].trg));
      chk("tbl_wrap", 0, 128'(wrapped[0]), 128'(0));
      step();
    end
    rd_ready = 0;

    // scenario: PC match at 0x2C after wrapping, drained under backpressure
    do_rearm();
    trig_pc_en = 1; trig_pc = 32'h2C;
    for (int k = 0; k < 12; k++) ret(32'(4 * k));
    chk("pm_state", 1, 128'(state[1]), 128'(2));
    chk("pm_count", 1, 128'(count[1]), 128'(8));
    chk("pm_wrapped", 1, 128'(wrapped[1]), 128'(1));
    chk("pm_first_pc", 1, 128'(rd_pc[1]), 128'(32'h10));
    xf = 0;
    for (int t = 0; t < 40 && xf < 8; t++) begin
      clear_pulses();
      rd_ready = pat[t % 4];
      #1;
      if (rd_valid[1] && rd_ready) begin
        chk("bp_pc", 1, 128'(rd_pc[1]), 128'(32'h10 + 32'(4 * xf)));
        xf++;
      end
      step();
    end
    chk("bp_xfers", 1, 128'(xf), 128'(8));
    chk("bp_done", 1, 128'(state[1]), 128'(3));
    rd_ready = 0; trig_pc_en = 0;

    // scenario: rearm while in POST beats a same-cycle retirement
    chk("pre_rearm_post", 0, 128'(state[0]), 128'(1));
    clear_pulses(); rearm = 1; set_ret(32'hDEAD00); step();
    chk("rearm_state", 0, 128'(state[0]), 128'(0));
    chk("rearm_count", 0, 128'(count[0]), 128'(0));
    chk("rearm_trig", 0, 128'(triggered[0]), 128'(0));
    ret(32'h300); ret(32'h304);
    clear_pulses(); trig_ext = 1; step();
    ret(32'h308); ret(32'h30C);
    chk("rearm_frozen", 0, 128'(state[0]), 128'(2));
    chk("rearm_cnt4", 0, 128'(count[0]), 128'(4));
    rd_ready = 1;
    for (int j = 0; j < 4; j++) begin
      chk("rearm_dump_pc", 0, 128'(rd_pc[0]), 128'(32'h300 + 32'(4 * j)));
      idle();
    end
    chk("rearm_done", 0, 128'(state[0]), 128'(3));
    rd_ready = 0;

    // scenario: stop-when-full ignores triggers and the 9th retirement
    do_rearm();
    for (int k = 0; k < 9; k++) begin
      clear_pulses(); set_ret(32'h400 + 32'(4 * k)); trig_ext = (k == 2); step();
    end
    chk("full_state", 2, 128'(state[2]), 128'(2));
    chk("full_count", 2, 128'(count[2]), 128'(8));
    chk("full_trig", 2, 128'(triggered[2]), 128'(0));
    rd_ready = 1;
    for (int j = 0; j < 8; j++) begin
      chk("full_pc", 2, 128'(rd_pc[2]), 128'(32'h400 + 32'(4 * j)));
      chk("full_last", 2, 128'(rd_last[2]), 128'(j == 7));
      idle();
    end
    chk("full_done", 2, 128'(state[2]), 128'(3));
    rd_ready = 0;

    // scenario: stamps 3 apart and a 4-bit stamp wrap, then reset mid-drain
    do_rearm();
    ret(32'h500); idle(); idle(); ret(32'h504);
    for (int k = 0; k < 10; k++) idle();
    ret(32'h508); ret(32'h50C); ret(32'h510);
    clear_pulses(); trig_ext = 1; step();
    chk("st_frozen", 1, 128'(state[1]), 128'(2));
    rd_ready = 1;
    for (int j = 0; j < 4; j++) begin
      chk("stamp", 1, 128'(stamp1), 128'(exp_st[j]));
      idle();
    end
    rd_ready = 0;
    chk("stamp_wrap", 1, 128'(stamp1), 128'(0));
    chk("stamp_wrap_pc", 1, 128'(rd_pc[1]), 128'(32'h510));
    clear_pulses(); rst = 1; step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_state", i, 128'(state[i]), 128'(0));
      chk("mid_rst_count", i, 128'(count[i]), 128'(0));
      chk("mid_rst_valid", i, 128'(rd_valid[i]), 128'(0));
      chk("mid_rst_last", i, 128'(rd_last[i]), 128'(0));
      chk("mid_rst_wrap", i, 128'(wrapped[i]), 128'(0));
      chk("mid_rst_trig", i, 128'(triggered[i]), 128'(0));
      chk("mid_rst_fields", i, 128'(dut_rec(i)), 128'(0));
    end

    // randomized traffic against the model
    trig_pc = 32'h24;
    for (int n = 0; n < 3000; n++) begin
      clear_pulses();
      en         = ($urandom_range(0, 9) != 0);
      ret_valid  = ($urandom_range(0, 9) < 6);
      ret_pc     = 32'($urandom_range(0, 15)) << 2;
      ret_instr  = $urandom;
      ret_data   = $urandom;
      ret_rd     = 5'($urandom);
      ret_wen    = 1'($urandom);
      trig_pc_en = 1'($urandom_range(0, 1));
      trig_ext   = ($urandom_range(0, 99) < 3);
      rd_ready   = ($urandom_range(0, 9) < 6);
      if (state[0] == 2'd3 && state[1] == 2'd3 && state[2] == 2'd3)
        rearm = ($urandom_range(0, 3) == 0);
      else
        rearm = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
